// File: rtl/cricket_scorer.sv
// Single-innings cricket scorer: each bowl rising edge draws one delivery outcome from rand_num
// and updates runs, wickets, balls and overs until the innings closes.
module cricket_scorer #(
  parameter int unsigned MAX_OVERS   = 2,
  parameter int unsigned MAX_WICKETS = 10
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic [3:0] rand_num,
  input  logic       bowl,
  input  logic       new_innings,
  output logic       busy,
  output logic       outcome_valid,
  output logic [3:0] outcome_code,
  output logic [9:0] runs_total,
  output logic [3:0] wickets,
  output logic [2:0] balls_in_over,
  output logic [3:0] overs,
  output logic       innings_over
);

  localparam logic [3:0] MaxOvers   = 4'(MAX_OVERS);
  localparam logic [3:0] MaxWickets = 4'(MAX_WICKETS);

  typedef enum logic [1:0] {StIdle, StDecode, StReport, StDone} state_e;

  state_e      state_q, state_d;
  logic        bowl_q;
  logic [3:0]  rand_q, rand_d;
  logic [3:0]  code_q, code_d;
  logic [9:0]  runs_q, runs_d;
  logic [3:0]  wickets_q, wickets_d;
  logic [2:0]  balls_q, balls_d;
  logic [3:0]  overs_q, overs_d;

  logic        rise;
  logic [3:0]  dec_code;
  logic [2:0]  dec_runs;
  logic        dec_legal;
  logic        dec_wicket;
  logic [10:0] run_sum;

  assign rise = bowl & ~bowl_q;

  always_comb begin
    dec_code = 4'd0;
    dec_runs = 3'd0;
    case (rand_q)
      4'd0, 4'd1, 4'd2:         begin dec_code = 4'd0; dec_runs = 3'd0; end
      4'd3, 4'd4, 4'd5, 4'd6:   begin dec_code = 4'd1; dec_runs = 3'd1; end
      4'd7, 4'd8, 4'd9:         begin dec_code = 4'd2; dec_runs = 3'd2; end
      4'd10:                    begin dec_code = 4'd3; dec_runs = 3'd3; end
      4'd11:                    begin dec_code = 4'd4; dec_runs = 3'd4; end
      4'd12:                    begin dec_code = 4'd5; dec_runs = 3'd6; end
      4'd13:                    begin dec_code = 4'd6; dec_runs = 3'd1; end
      4'd14:                    begin dec_code = 4'd7; dec_runs = 3'd1; end
      default:                  begin dec_code = 4'd8; dec_runs = 3'd0; end
    endcase
    dec_legal  = (dec_code != 4'd6) && (dec_code != 4'd7);
    dec_wicket = (dec_code == 4'd8);
    run_sum    = {1'b0, runs_q} + 11'(dec_runs);
  end

  always_comb begin
    state_d   = state_q;
    rand_d    = rand_q;
    code_d    = code_q;
    runs_d    = runs_q;
    wickets_d = wickets_q;
    balls_d   = balls_q;
    overs_d   = overs_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (new_innings) begin
          state_d   = StIdle;
          code_d    = 4'd0;
          runs_d    = 10'd0;
          wickets_d = 4'd0;
          balls_d   = 3'd0;
          overs_d   = 4'd0;
        end else if (rise && (state_q == StIdle)) begin
          rand_d  = rand_num;
          state_d = StDecode;
        end
      end
      StDecode: begin
        code_d = dec_code;
        runs_d = run_sum[10] ? 10'd1023 : run_sum[9:0];
        if (dec_legal) begin
          if (balls_q == 3'd5) begin
            balls_d = 3'd0;
            overs_d = overs_q + 4'd1;
          end else begin
            balls_d = balls_q + 3'd1;
          end
        end
        if (dec_wicket) wickets_d = wickets_q + 4'd1;
        state_d = StReport;
      end
      StReport: begin
        state_d = ((overs_q == MaxOvers) || (wickets_q == MaxWickets)) ? StDone : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_fpga) begin
    if (!reset) begin
      state_q   <= StIdle;
      bowl_q    <= 1'b1;  // a bowl held through reset must not look like a new request
      rand_q    <= 4'd0;
      code_q    <= 4'd0;
      runs_q    <= 10'd0;
      wickets_q <= 4'd0;
      balls_q   <= 3'd0;
      overs_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      bowl_q    <= bowl;
      rand_q    <= rand_d;
      code_q    <= code_d;
      runs_q    <= runs_d;
      wickets_q <= wickets_d;
      balls_q   <= balls_d;
      overs_q   <= overs_d;
    end
  end

  assign busy          = (state_q == StDecode) || (state_q == StReport);
  assign outcome_valid = (state_q == StReport);
  assign innings_over  = (state_q == StDone);
  assign outcome_code  = code_q;
  assign runs_total    = runs_q;
  assign wickets       = wickets_q;
  assign balls_in_over = balls_q;
  assign overs         = overs_q;

endmodule

// File: tb/tb_cricket_scorer.sv
// Bench for cricket_scorer: decode table, directed corner sequences and a randomized innings run
// against a counting model; a second instance uses a two-wicket innings.
module tb_cricket_scorer;

  localparam int MaxOversA   = 2;
  localparam int MaxWicketsA = 10;

  logic       clk_fpga = 1'b0;
  logic       reset;
  logic [3:0] rand_num;
  logic       bowl_a, bowl_b;
  logic       new_innings;

  logic       busy_a, valid_a, io_a;
  logic [3:0] code_a, wk_a, ov_a;
  logic [9:0] runs_a;
  logic [2:0] bio_a;
  logic       busy_b, valid_b, io_b;
  logic [3:0] code_b, wk_b, ov_b;
  logic [9:0] runs_b;
  logic [2:0] bio_b;

  always #5 clk_fpga = ~clk_fpga;

  cricket_scorer #(.MAX_OVERS(MaxOversA), .MAX_WICKETS(MaxWicketsA)) dut_a (
    .clk_fpga(clk_fpga), .reset(reset), .rand_num(rand_num), .bowl(bowl_a),
    .new_innings(new_innings), .busy(busy_a), .outcome_valid(valid_a), .outcome_code(code_a),
    .runs_total(runs_a), .wickets(wk_a), .balls_in_over(bio_a), .overs(ov_a),
    .innings_over(io_a)
  );

  cricket_scorer #(.MAX_OVERS(2), .MAX_WICKETS(2)) dut_b (
    .clk_fpga(clk_fpga), .reset(reset), .rand_num(rand_num), .bowl(bowl_b),
    .new_innings(new_innings), .busy(busy_b), .outcome_valid(valid_b), .outcome_code(code_b),
    .runs_total(runs_b), .wickets(wk_b), .balls_in_over(bio_b), .overs(ov_b),
    .innings_over(io_b)
  );

  typedef struct {
    logic [3:0] rn;
    int         code;
    int         runs;
    int         legal;
    int         wkt;
  } vec_t;

  vec_t tab[16];
  int   n_pass = 0;
  int   n_total = 0;
  int   vcnt_a = 0;
  int   vcnt_b = 0;

  // model: totals only; balls/overs derived from the count of legal balls
  int m_runs, m_wk, m_legal, m_code;

  always @(negedge clk_fpga) begin
    if (valid_a) vcnt_a++;
    if (valid_b) vcnt_b++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic bit m_done();
    return ((m_legal / 6) >= MaxOversA) || (m_wk >= MaxWicketsA);
  endfunction

  task automatic step();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_runs"}, runs_a, m_runs);
    chk({tag, "_wk"}, wk_a, m_wk);
    chk({tag, "_bio"}, bio_a, m_legal % 6);
    chk({tag, "_ov"}, ov_a, m_legal / 6);
    chk({tag, "_code"}, code_a, m_code);
  endtask

  task automatic model_reset();
    m_runs = 0; m_wk = 0; m_legal = 0; m_code = 0;
  endtask

  task automatic new_inn(input bit with_bowl);
    new_innings = 1'b1;
    if (with_bowl) bowl_a = 1'b1;
    step();
    new_innings = 1'b0;
    model_reset();
    chk("newinn_busy", busy_a, 0);
    chk("newinn_io", io_a, 0);
    chk_state("newinn");
    if (with_bowl) begin
      bowl_a = 1'b0;
      step();
      chk("newinn_bowl_busy", busy_a, 0);
    end
  endtask

  task automatic deliver(input logic [3:0] rn);
    int v0;
    bit acc;
    acc = !m_done();
    v0 = vcnt_a;
    rand_num = rn;
    bowl_a = 1'b1;
    step();
    if (acc) chk("busy_decode", busy_a, 1);
    bowl_a = 1'b0;
    rand_num = 4'($urandom);
    step();
    if (acc) begin
      m_runs = (m_runs + tab[rn].runs > 1023) ? 1023 : m_runs + tab[rn].runs;
      m_legal += tab[rn].legal;
      m_wk += tab[rn].wkt;
      m_code = tab[rn].code;
      chk("valid_report", valid_a, 1);
      chk("busy_report", busy_a, 1);
      chk_state("report");
    end
    step();
    chk("busy_after", busy_a, 0);
    chk("pulses", vcnt_a - v0, acc ? 1 : 0);
    chk("innings_over", io_a, m_done());
    if (!acc) chk_state("hold");
  endtask

  initial begin
    tab[0]  = '{4'd0, 0, 0, 1, 0};
    tab[1]  = '{4'd1, 0, 0, 1, 0};
    tab[2]  = '{4'd2, 0, 0, 1, 0};
    tab[3]  = '{4'd3, 1, 1, 1, 0};
    tab[4]  = '{4'd4, 1, 1, 1, 0};
    tab[5]  = '{4'd5, 1, 1, 1, 0};
    tab[6]  = '{4'd6, 1, 1, 1, 0};
    tab[7]  = '{4'd7, 2, 2, 1, 0};
    tab[8]  = '{4'd8, 2, 2, 1, 0};
    tab[9]  = '{4'd9, 2, 2, 1, 0};
    tab[10] = '{4'd10, 3, 3, 1, 0};
    tab[11] = '{4'd11, 4, 4, 1, 0};
    tab[12] = '{4'd12, 5, 6, 1, 0};
    tab[13] = '{4'd13, 6, 1, 0, 0};
    tab[14] = '{4'd14, 7, 1, 0, 0};
    tab[15] = '{4'd15, 8, 0, 1, 1};
    model_reset();

    // reset with bowl held high, then release while still high
    reset = 1'b0; bowl_a = 1'b1; bowl_b = 1'b1; new_innings = 1'b0; rand_num = 4'd12;
    step(); step();
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_io", io_a, 0);
    chk_state("rst");
    reset = 1'b1;
    step(); step(); step();
    chk("rst_hold_pulses", vcnt_a, 0);
    chk("rst_hold_busy", busy_a, 0);
    bowl_a = 1'b0; bowl_b = 1'b0;
    step();

    // single six: latency and busy width
    deliver(4'd12);
    chk("six_code", code_a, 5);
    chk("six_runs", runs_a, 6);
    chk("six_bio", bio_a, 1);

    // decode table, one fresh innings per entry
    for (int i = 0; i < 16; i++) begin
      new_inn(1'b0);
      deliver(tab[i].rn);
      chk("tab_code", code_a, tab[i].code);
      chk("tab_runs", runs_a, tab[i].runs);
      chk("tab_bio", bio_a, tab[i].legal);
      chk("tab_wk", wk_a, tab[i].wkt);
    end

    // over completion, then a wide leaves balls/overs alone
    new_inn(1'b0);
    repeat (6) deliver(4'd4);
    chk("over_runs", runs_a, 6);
    chk("over_bio", bio_a, 0);
    chk("over_ov", ov_a, 1);
    deliver(4'd13);
    chk("wide_runs", runs_a, 7);
    chk("wide_bio", bio_a, 0);
    chk("wide_ov", ov_a, 1);

    // second rise during the delivery is dropped
    begin
      int v0;
      v0 = vcnt_a;
      rand_num = 4'd3; bowl_a = 1'b1; step();
      bowl_a = 1'b0; step();
      bowl_a = 1'b1; step();
      chk("dbl_busy", busy_a, 0);
      bowl_a = 1'b0; step(); step();
      chk("dbl_pulses", vcnt_a - v0, 1);
      chk("dbl_runs", runs_a, 8);
      chk("dbl_bio", bio_a, 1);
      m_runs = 8; m_legal = 7; m_code = 1;
    end

    // new_innings wins over a simultaneous rise
    new_inn(1'b1);

    // reset mid-delivery aborts it
    deliver(4'd11);
    begin
      int v0;
      v0 = vcnt_a;
      rand_num = 4'd12; bowl_a = 1'b1; step();
      chk("abort_in_decode", busy_a, 1);
      reset = 1'b0; step();
      model_reset();
      chk("abort_busy", busy_a, 0);
      chk("abort_valid", valid_a, 0);
      chk_state("abort");
      reset = 1'b1; step(); step(); step();
      chk("abort_pulses", vcnt_a - v0, 0);
      chk("abort_hold_runs", runs_a, 0);
      bowl_a = 1'b0; step();
    end

    // two-wicket innings on the second instance
    new_inn(1'b0);
    begin
      int v0;
      repeat (2) begin
        rand_num = 4'd15; bowl_b = 1'b1; step();
        bowl_b = 1'b0; step(); step();
      end
      chk("b_wk", wk_b, 2);
      chk("b_io", io_b, 1);
      v0 = vcnt_b;
      rand_num = 4'd12; bowl_b = 1'b1; step();
      bowl_b = 1'b0; step(); step();
      chk("b_ignored_pulses", vcnt_b - v0, 0);
      chk("b_ignored_runs", runs_b, 0);
      new_inn(1'b0);
      chk("b_clr_wk", wk_b, 0);
      chk("b_clr_io", io_b, 0);
      chk("b_clr_bio", bio_b, 0);
      chk("b_clr_code", code_b, 0);
    end

    // saturation near 1023
    new_inn(1'b0);
    repeat (1020) deliver(4'd13);
    chk("pre_runs", runs_a, 1020);
    deliver(4'd12);
    chk("sat_six", runs_a, 1023);
    deliver(4'd11);
    chk("sat_four", runs_a, 1023);

    // randomized innings
    new_inn(1'b0);
    repeat (400) begin
      deliver(4'($urandom_range(0, 15)));
      if (m_done() && ($urandom_range(0, 2) == 0)) new_inn(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
